// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path (binary score -> packed BCD digits).
package score_display_pkg;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 16;
   localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Saturation pattern: the lowest 'digits' nibbles set to 9, everything above zero.
   function automatic logic [DIGIT_W*MAX_DIGITS-1:0] digit_sat_all9(input int digits);
      logic [DIGIT_W*MAX_DIGITS-1:0] sat;
      sat = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) begin
            sat[i*DIGIT_W +: DIGIT_W] = 4'd9;
         end
      end
      return sat;
   endfunction

endpackage

// File: rtl/score_bcd_converter_add3_cell.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more, before the shift.
module bcd_add3_cell (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the score display.
// Optional build macro SCORE_BCD_BLANK_EN: leading zeros above the ones digit are shown as blank code.
module score_bcd_converter
   import score_display_pkg::*;
#(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 6
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam logic [DIGIT_W*MAX_DIGITS-1:0] SAT_FULL = digit_sat_all9(DIGITS);
   localparam logic [BCD_W-1:0] SAT_VAL = SAT_FULL[BCD_W-1:0];
`ifdef SCORE_BCD_BLANK_EN
   localparam logic [BCD_W-1:0] RESET_BCD = {DIGITS{BCD_BLANK}} ^ BCD_W'(BCD_BLANK);
`else
   localparam logic [BCD_W-1:0] RESET_BCD = '0;
`endif

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_W-1:0]   r_shift;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_ovfS;
   logic [BCD_W-1:0]   r_bcdOut;
   logic               r_overflow;
   logic               r_done;
   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_display;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_cells
         bcd_add3_cell u_cell (
            .i_digit (r_bcd[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
         );
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      busy        = (r_state != IDLE);
      case (r_state)
         IDLE:    if (start) w_nextState = SHIFT;
         SHIFT:   if (r_cnt == CNT_W'(1)) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

`ifdef SCORE_BCD_BLANK_EN
   // Walk down from the top digit, blanking zeros until the first non-zero; ones stays numeric.
   always_comb begin
      logic lead;
      w_display = r_bcd;
      lead      = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (r_bcd[i*DIGIT_W +: DIGIT_W] == 4'd0)) begin
            w_display[i*DIGIT_W +: DIGIT_W] = BCD_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   always_comb begin
      w_display = r_bcd;
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_ovfS     <= 1'b0;
         r_bcdOut   <= RESET_BCD;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shift <= bin_in;
                  r_bcd   <= '0;
                  r_ovfS  <= 1'b0;
                  r_cnt   <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               // A bit leaving the top digit means the value no longer fits in DIGITS digits.
               {r_bcd, r_shift} <= {w_adj[BCD_W-2:0], r_shift, 1'b0};
               r_ovfS           <= r_ovfS | w_adj[BCD_W-1];
               r_cnt            <= r_cnt - CNT_W'(1);
            end
            DONE: begin
               r_bcdOut   <= r_ovfS ? SAT_VAL : w_display;
               r_overflow <= r_ovfS;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd_out  = r_bcdOut;
   assign overflow = r_overflow;
   assign done     = r_done;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: decimal reference model, directed corner cases, random scores.
module tb_score_bcd_converter;

   localparam int BIN_W  = 32;
   localparam int DIGITS = 6;
   localparam int LAT    = BIN_W + 1;

`ifdef SCORE_BCD_BLANK_EN
   localparam logic [23:0] RESET_VAL = 24'hFFFFF0;
`else
   localparam logic [23:0] RESET_VAL = 24'h000000;
`endif

   typedef struct {
      logic [23:0] bcd;
      logic        ovf;
      int          due;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [31:0] bin_in;
   logic        busy;
   logic        done;
   logic [23:0] bcd_out;
   logic        overflow;

   exp_t        sbQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [23:0] lastBcd = RESET_VAL;
   logic        lastOvf = 1'b0;

   score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Decimal reference: saturate above 999999, otherwise split into base-10 digits.
   function automatic exp_t refModel(input int unsigned v);
      exp_t        e;
      int unsigned rem;
      int unsigned p;
      e.due = 0;
      e.bcd = '0;
      if (v > 32'd999999) begin
         e.bcd = 24'h999999;
         e.ovf = 1'b1;
      end else begin
         e.ovf = 1'b0;
         rem   = v;
         for (int i = 0; i < DIGITS; i++) begin
            e.bcd[i*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
         end
`ifdef SCORE_BCD_BLANK_EN
         p = 1;
         for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            if (v < p) e.bcd[i*4 +: 4] = 4'hF;
         end
`else
         p = 0;
`endif
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Issue one conversion, then toggle start and bin_in randomly while the DUT must ignore them.
   task automatic applyStimulus(input int unsigned v);
      exp_t e;
      start  = 1'b1;
      bin_in = v;
      @(posedge clock); #1;
      e     = refModel(v);
      e.due = cyc + LAT;
      sbQ.push_back(e);
      start = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         bin_in = $urandom;
         start  = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         if (i == 5) checkOutput("busy_mid", busy, 1);
      end
      start = 1'b0;
      checkOutput("busy_after", busy, 0);
   endtask

   // Monitor: pop on every done pulse, otherwise outputs must hold their last value.
   always @(negedge clock) begin
      exp_t e;
      if (!resetn) begin
         lastBcd = RESET_VAL;
         lastOvf = 1'b0;
      end else if (done) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            e = sbQ.pop_front();
            checkOutput("bcd_out", bcd_out, e.bcd);
            checkOutput("overflow", overflow, e.ovf);
            checkOutput("done_cycle", cyc, e.due);
            lastBcd = e.bcd;
            lastOvf = e.ovf;
         end
      end else begin
         checkOutput("bcd_hold", bcd_out, lastBcd);
         checkOutput("ovf_hold", overflow, lastOvf);
      end
   end

   initial begin
      repeat (50000) @(posedge clock);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      int unsigned v;
      int wait_cnt;

      resetn = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) @(posedge clock); #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_bcd", bcd_out, RESET_VAL);
      checkOutput("rst_ovf", overflow, 0);
      resetn = 1'b1;
      @(posedge clock); #1;

      applyStimulus(7617);
      applyStimulus(0);
      applyStimulus(999999);
      applyStimulus(1000000);
      applyStimulus(32'hFFFFFFFF);
      applyStimulus(42);
      applyStimulus(58);

      // start held for 40 edges: 123 converts, then 456 on the first IDLE edge.
      start  = 1'b1;
      bin_in = 123;
      @(posedge clock); #1;
      e     = refModel(123);
      e.due = cyc + LAT;
      sbQ.push_back(e);
      bin_in = 456;
      repeat (LAT) @(posedge clock); #1;
      @(posedge clock); #1;
      e     = refModel(456);
      e.due = cyc + LAT;
      sbQ.push_back(e);
      repeat (5) @(posedge clock); #1;
      start = 1'b0;
      repeat (28) @(posedge clock); #1;

      // Reset in the middle of a conversion.
      start  = 1'b1;
      bin_in = 4321;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock); #1;
      checkOutput("busy_pre_reset", busy, 1);
      resetn = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_bcd", bcd_out, RESET_VAL);
      checkOutput("abort_ovf", overflow, 0);
      repeat (3) @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      applyStimulus(4321);

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 999);
            1:       v = $urandom_range(0, 999999);
            2:       v = $urandom;
            default: v = $urandom_range(999990, 1000009);
         endcase
         applyStimulus(v);
      end

      wait_cnt = 0;
      while (sbQ.size() != 0 && wait_cnt < 100) begin
         @(posedge clock); #1;
         wait_cnt++;
      end
      checkOutput("sb_drained", sbQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
